dmem_unit: RTL and testbench

DMEM_UNIT -- requirements
Module: dmem_unit

---
 rtl/dmem_pkg.sv | 62 ++++++
 rtl/dmem_unit_lane_fmt.sv | 27 ++
 rtl/dmem_unit.sv | 147 ++++++++++++++
 tb/tb_dmem_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access sizes, FSM states,
// and the lane merge/extract helpers used on the store and load paths.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } st_lanes_t;

  // Replicate right-justified store data across lanes; byte enables pick the target.
  function automatic st_lanes_t lane_merge(input logic [31:0] wdata,
                                           input logic [1:0]  off,
                                           input logic [1:0]  size);
    st_lanes_t r;
    r.be   = 4'b0000;
    r.data = '0;
    case (size)
      SZ_B: begin
        r.be   = 4'b0001 << off;
        r.data = {4{wdata[7:0]}};
      end
      SZ_H: begin
        r.be   = 4'b0011 << off;
        r.data = {2{wdata[15:0]}};
      end
      SZ_W: begin
        r.be   = 4'b1111;
        r.data = wdata;
      end
      default: begin
        r.be   = 4'b0000;
        r.data = '0;
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    r = uns ? {24'b0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    r = uns ? {16'b0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_unit_lane_fmt.sv
// Combinational lane formatting: store byte enables / replicated data and
// load lane extraction with sign or zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  st_lanes_t lanes;

  always_comb begin
    lanes   = lane_merge(st_wdata, st_off, st_size);
    st_be   = lanes.be;
    st_word = lanes.data;
    ld_data = lane_extract(ld_word, ld_off, ld_size, ld_unsigned);
  end

endmodule

// File: rtl/dmem_unit.sv
// Data memory unit: DEPTH x 32 byte-writable RAM with a post-reset clear
// sequence and a fixed one-cycle request/response protocol.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic            clr_we;
  logic            clr_last;
  logic            accept;
  logic            req_err;

  logic [AW-1:0]   ram_idx;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;
  logic [31:0]     rd_q;
  logic [31:0]     mem [DEPTH];

  logic [3:0]      st_be;
  logic [31:0]     st_word;
  logic [31:0]     ld_data;

  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic            rsp_ld_q;
  logic [1:0]      rsp_off_q;
  logic [1:0]      rsp_size_q;
  logic            rsp_uns_q;

  assign clr_last = (clr_idx == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = !rst;
        if (clr_last) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) state_nxt = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
  end

  // Index wraps back to zero after the last word, leaving it ready for the next clear.
  always_ff @(posedge clk) begin
    if (rst)                   clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  assign accept = req_valid && req_ready && !rst;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = req_addr[0];
      SZ_W:    req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH)) req_err = 1'b1;
  end

  dmem_lane_fmt u_fmt (
    .st_size     (req_size),
    .st_off      (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_be       (st_be),
    .st_word     (st_word),
    .ld_word     (rd_q),
    .ld_off      (rsp_off_q),
    .ld_size     (rsp_size_q),
    .ld_unsigned (rsp_uns_q),
    .ld_data     (ld_data)
  );

  always_comb begin
    ram_idx   = clr_we ? clr_idx : req_addr[AW+1:2];
    ram_wdata = clr_we ? '0 : st_word;
    ram_be    = 4'b0000;
    if (clr_we)                             ram_be = 4'b1111;
    else if (accept && req_we && !req_err) ram_be = st_be;
  end

  // Read-first single port: a load sees the word as it was before this edge.
  always_ff @(posedge clk) begin
    rd_q <= mem[ram_idx];
    for (int unsigned b = 0; b < 4; b++) begin
      if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && req_err;
      rsp_ld_q    <= accept && !req_we && !req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rsp_off_q  <= req_addr[1:0];
      rsp_size_q <= req_size;
      rsp_uns_q  <= req_unsigned;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_ld_q ? ld_data : '0;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit (DEPTH=16): directed scenarios plus
// randomized traffic against a byte-addressed reference memory.
module tb_dmem_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] mb [0:4*DEPTH-1];

  dmem_unit #(.DEPTH(DEPTH), .CLEAR_ON_RST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (addr / 4 >= DEPTH) return 1'b1;
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = '0;
    for (int i = 0; i < n; i++) v |= 32'(mb[6'(addr + 32'(i))]) << (8 * i);
    if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) mb[6'(addr + 32'(i))] = 8'(wdata >> (8 * i));
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4 * DEPTH; i++) mb[i] = 8'h00;
  endtask

  // One accepted request; its response is checked one cycle later.
  task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic e;
    logic [31:0] exp;
    e   = model_err(addr, size);
    exp = (e || we) ? 32'h0 : model_load(addr, size, uns);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we && !e) model_store(addr, size, wdata);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"},   32'(rsp_err),   32'(e));
    chk({tag, "_rdata"}, rsp_rdata, exp);
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd1);
    chk({tag, "_ready"},     32'(req_ready), 32'd0);
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk({tag, "_cycles"}, 32'(cnt), 32'(DEPTH));
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    model_zero();
  endtask

  task automatic read_all(input string tag);
    for (int w = 0; w < DEPTH; w++) xfer(1'b0, 2'd2, 1'b0, 32'(4 * w), 32'h0, tag);
  endtask

  initial begin
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr;
    int          r;

    // Power-on reset and full clear
    reset_cycle("rst0");
    count_busy("clr0");
    read_all("zero0");

    // Store word then signed/unsigned byte loads
    xfer(1'b1, 2'd2, 1'b0, 32'h8, 32'h8000_00F0, "sw8");
    xfer(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, "lb8s");
    chk("lb8s_lit", rsp_rdata, 32'hFFFF_FFF0);
    xfer(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, "lb8u");
    chk("lb8u_lit", rsp_rdata, 32'h0000_00F0);

    // Upper-half store then word load
    xfer(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_1234, "sh6");
    xfer(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw4");
    chk("lw4_lit", rsp_rdata, 32'h1234_0000);

    // Illegal accesses, including stores that must not land anywhere
    xfer(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, "lh3");
    xfer(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, "lw2");
    xfer(1'b0, 2'd3, 1'b0, 32'h4, 32'h0, "sz11");
    xfer(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, "lwoor");
    xfer(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'hDEAD_BEEF, "swoor");
    xfer(1'b1, 2'd1, 1'b0, 32'h5, 32'hCAFE, "shmis");
    xfer(1'b1, 2'd3, 1'b0, 32'h8, 32'h1111_1111, "sw11");
    read_all("unchg");

    // Back-to-back store then load of the same word
    xfer(1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A5_A5A5, "b2b_sw");
    xfer(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "b2b_lw");
    chk("b2b_lit", rsp_rdata, 32'hA5A5_A5A5);

    // Randomized traffic with occasional idle cycles
    for (int k = 0; k < 300; k++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 7));
      size = (r < 7) ? 2'(r % 3) : 2'd3;
      addr = 32'($urandom_range(0, 4 * DEPTH + 15));
      if (size != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(size) - 1);
      xfer(we, size, uns, addr, $urandom, "rnd");
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        chk("idle_valid", 32'(rsp_valid), 32'd0);
      end
    end
    read_all("rnd_end");

    // Reset on clear cycle 5 restarts the full clear
    reset_cycle("rst1");
    repeat (4) @(posedge clk);
    #1;
    chk("clr5_busy", 32'(busy), 32'd1);
    reset_cycle("rst_mid");
    count_busy("clr1");

    // Reset while a load response is visible and another load is presented
    xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'h1357_9BDF, "pre_sw");
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    chk("pend_valid", 32'(rsp_valid), 32'd1);
    chk("pend_rdata", rsp_rdata, 32'h1357_9BDF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("drop_valid", 32'(rsp_valid), 32'd0);
    chk("drop_rdata", rsp_rdata, 32'd0);
    chk("drop_err",   32'(rsp_err), 32'd0);
    chk("drop_busy",  32'(busy), 32'd1);
    count_busy("clr2");
    read_all("zero2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
